// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-direction traffic light sequencer with a countdown display for each
//   direction and a flashing-yellow night mode.
//   Normal cycle: G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1.
//   Night mode is entered from the end of an all-red phase and left through
//   one AR2 clearance phase.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rs        : asynchronous active-high reset
//   night     : night-mode request level, sampled on ticks only
//   X1/V1/D1  : direction-1 green / yellow / red lamps
//   X2/V2/D2  : direction-2 green / yellow / red lamps
//   counter1  : ticks remaining on direction-1's current lamp (saturating)
//   counter2  : ticks remaining on direction-2's current lamp (saturating)
module traffic_light_ctrl #(
  parameter int CW       = 8,
  parameter int T_GREEN  = 15,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 1,
  parameter int T_FLASH  = 2,
  parameter int TICK_DIV = 1
) (
  input  logic          clk,
  input  logic          rs,
  input  logic          night,
  output logic          X1,
  output logic          V1,
  output logic          D1,
  output logic          X2,
  output logic          V2,
  output logic          D2,
  output logic [CW-1:0] counter1,
  output logic [CW-1:0] counter2
);

  localparam int TMAX_GY = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int TMAX_AF = (T_ALLRED > T_FLASH) ? T_ALLRED : T_FLASH;
  localparam int TMAX    = (TMAX_GY > TMAX_AF) ? TMAX_GY : TMAX_AF;
  localparam int CNTW    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Display arithmetic width: wide enough for any sum of the phase lengths.
  localparam int DW      = (CW + 2 > 34) ? CW + 2 : 34;

  localparam logic [DW-1:0] K_G   = DW'(T_GREEN);
  localparam logic [DW-1:0] K_Y   = DW'(T_YELLOW);
  localparam logic [DW-1:0] K_AR  = DW'(T_ALLRED);
  localparam logic [DW-1:0] K_ONE = DW'(1);
  localparam logic [DW-1:0] K_SAT = {{(DW-CW){1'b0}}, {CW{1'b1}}};

  localparam logic [CNTW-1:0] C_GREEN  = CNTW'(T_GREEN - 1);
  localparam logic [CNTW-1:0] C_YELLOW = CNTW'(T_YELLOW - 1);
  localparam logic [CNTW-1:0] C_ALLRED = CNTW'(T_ALLRED - 1);
  localparam logic [CNTW-1:0] C_FLASH  = CNTW'(T_FLASH - 1);
  localparam logic [PW-1:0]   P_LAST   = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_G1, S_Y1, S_AR1, S_G2, S_Y2, S_AR2, S_NF_ON, S_NF_OFF
  } state_t;

  typedef struct packed {
    logic          x1;
    logic          v1;
    logic          d1;
    logic          x2;
    logic          v2;
    logic          d2;
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;
  } disp_t;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [PW-1:0]   r_presc;
  disp_t           r_disp;

  state_t          w_state_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_tick;

  function automatic logic [CW-1:0] sat(input logic [DW-1:0] v);
    return (v > K_SAT) ? '1 : v[CW-1:0];
  endfunction

  // Lamp and display decode for a given state / phase count.
  function automatic disp_t decode(input state_t s, input logic [CNTW-1:0] c);
    disp_t           d;
    logic [DW-1:0]   rem;
    d   = '0;
    rem = DW'(c) + K_ONE;
    case (s)
      S_G1: begin
        d.x1 = 1'b1; d.d2 = 1'b1;
        d.c1 = sat(rem);
        d.c2 = sat(rem + K_Y + K_AR);
      end
      S_Y1: begin
        d.v1 = 1'b1; d.d2 = 1'b1;
        d.c1 = sat(rem);
        d.c2 = sat(rem + K_AR);
      end
      S_AR1: begin
        d.d1 = 1'b1; d.d2 = 1'b1;
        d.c1 = sat(rem + K_G + K_Y + K_AR);
        d.c2 = sat(rem);
      end
      S_G2: begin
        d.d1 = 1'b1; d.x2 = 1'b1;
        d.c1 = sat(rem + K_Y + K_AR);
        d.c2 = sat(rem);
      end
      S_Y2: begin
        d.d1 = 1'b1; d.v2 = 1'b1;
        d.c1 = sat(rem + K_AR);
        d.c2 = sat(rem);
      end
      S_AR2: begin
        d.d1 = 1'b1; d.d2 = 1'b1;
        d.c1 = sat(rem);
        d.c2 = sat(rem + K_G + K_Y + K_AR);
      end
      S_NF_ON: begin
        d.v1 = 1'b1; d.v2 = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

  assign w_tick = (r_presc == P_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_tick) begin
      if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CNTW'(1);
      end else begin
        case (r_state)
          S_G1:  begin w_state_nxt = S_Y1;  w_cnt_nxt = C_YELLOW; end
          S_Y1:  begin w_state_nxt = S_AR1; w_cnt_nxt = C_ALLRED; end
          S_AR1: begin
            if (night) begin w_state_nxt = S_NF_ON; w_cnt_nxt = C_FLASH; end
            else       begin w_state_nxt = S_G2;    w_cnt_nxt = C_GREEN; end
          end
          S_G2:  begin w_state_nxt = S_Y2;  w_cnt_nxt = C_YELLOW; end
          S_Y2:  begin w_state_nxt = S_AR2; w_cnt_nxt = C_ALLRED; end
          S_AR2: begin
            if (night) begin w_state_nxt = S_NF_ON; w_cnt_nxt = C_FLASH; end
            else       begin w_state_nxt = S_G1;    w_cnt_nxt = C_GREEN; end
          end
          S_NF_ON: begin
            if (night) begin w_state_nxt = S_NF_OFF; w_cnt_nxt = C_FLASH; end
            else       begin w_state_nxt = S_AR2;    w_cnt_nxt = C_ALLRED; end
          end
          S_NF_OFF: begin
            if (night) begin w_state_nxt = S_NF_ON; w_cnt_nxt = C_FLASH; end
            else       begin w_state_nxt = S_AR2;   w_cnt_nxt = C_ALLRED; end
          end
          default: begin w_state_nxt = S_AR2; w_cnt_nxt = C_ALLRED; end
        endcase
      end
    end
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state register; reset loads the G1 decode directly.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      r_state <= S_G1;
      r_cnt   <= C_GREEN;
      r_presc <= '0;
      r_disp  <= decode(S_G1, C_GREEN);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      r_disp  <= decode(w_state_nxt, w_cnt_nxt);
    end
  end

  assign X1       = r_disp.x1;
  assign V1       = r_disp.v1;
  assign D1       = r_disp.d1;
  assign X2       = r_disp.x2;
  assign V2       = r_disp.v2;
  assign D2       = r_disp.d2;
  assign counter1 = r_disp.c1;
  assign counter2 = r_disp.c2;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Testbench for traffic_light_ctrl: default configuration, a saturating
// display configuration (T_GREEN=250) and a prescaled one (TICK_DIV=4).
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rs  = 1'b1;
  logic       night = 1'b0;

  logic       X1, V1, D1, X2, V2, D2;
  logic [7:0] counter1, counter2;
  logic       bX1, bV1, bD1, bX2, bV2, bD2;
  logic [7:0] bc1, bc2;
  logic       cX1, cV1, cD1, cX2, cV2, cD2;
  logic [7:0] cc1, cc2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl u_a (
    .clk(clk), .rs(rs), .night(night),
    .X1(X1), .V1(V1), .D1(D1), .X2(X2), .V2(V2), .D2(D2),
    .counter1(counter1), .counter2(counter2)
  );

  traffic_light_ctrl #(.CW(8), .T_GREEN(250)) u_b (
    .clk(clk), .rs(rs), .night(1'b0),
    .X1(bX1), .V1(bV1), .D1(bD1), .X2(bX2), .V2(bV2), .D2(bD2),
    .counter1(bc1), .counter2(bc2)
  );

  traffic_light_ctrl #(.TICK_DIV(4)) u_c (
    .clk(clk), .rs(rs), .night(1'b0),
    .X1(cX1), .V1(cV1), .D1(cD1), .X2(cX2), .V2(cV2), .D2(cD2),
    .counter1(cc1), .counter2(cc2)
  );

  typedef struct {
    bit         rst;
    int         cyc;
    logic       nt;
    logic [5:0] lamps;
    logic [7:0] c1;
    logic [7:0] c2;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reset held across one rising edge, released on a falling edge: that
  // falling edge is cycle 0.
  task automatic do_reset();
    rs    = 1'b1;
    night = 1'b0;
    @(negedge clk);
    rs  = 1'b0;
    cur = 0;
  endtask

  task automatic step_to(input int target);
    while (cur < target) begin
      @(negedge clk);
      cur++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Default configuration, night=0, two full 42-cycle periods.
    tbl.push_back('{1,  0, 0, 6'b100001, 15, 21});
    tbl.push_back('{0,  7, 0, 6'b100001,  8, 14});
    tbl.push_back('{0, 14, 0, 6'b100001,  1,  7});
    tbl.push_back('{0, 15, 0, 6'b010001,  5,  6});
    tbl.push_back('{0, 19, 0, 6'b010001,  1,  2});
    tbl.push_back('{0, 20, 0, 6'b001001, 22,  1});
    tbl.push_back('{0, 21, 0, 6'b001100, 21, 15});
    tbl.push_back('{0, 35, 0, 6'b001100,  7,  1});
    tbl.push_back('{0, 36, 0, 6'b001010,  6,  5});
    tbl.push_back('{0, 40, 0, 6'b001010,  2,  1});
    tbl.push_back('{0, 41, 0, 6'b001001,  1, 22});
    tbl.push_back('{0, 42, 0, 6'b100001, 15, 21});
    tbl.push_back('{0, 62, 0, 6'b001001, 22,  1});
    tbl.push_back('{0, 83, 0, 6'b001001,  1, 22});
    tbl.push_back('{0, 84, 0, 6'b100001, 15, 21});
    // Night raised at cycle 3, dropped on the first cycle of an NF_ON.
    tbl.push_back('{1,  0, 0, 6'b100001, 15, 21});
    tbl.push_back('{0,  3, 1, 6'b100001, 12, 18});
    tbl.push_back('{0, 15, 1, 6'b010001,  5,  6});
    tbl.push_back('{0, 20, 1, 6'b001001, 22,  1});
    tbl.push_back('{0, 21, 1, 6'b010010,  0,  0});
    tbl.push_back('{0, 22, 1, 6'b010010,  0,  0});
    tbl.push_back('{0, 23, 1, 6'b000000,  0,  0});
    tbl.push_back('{0, 24, 1, 6'b000000,  0,  0});
    tbl.push_back('{0, 25, 0, 6'b010010,  0,  0});
    tbl.push_back('{0, 26, 0, 6'b010010,  0,  0});
    tbl.push_back('{0, 27, 0, 6'b001001,  1, 22});
    tbl.push_back('{0, 28, 0, 6'b100001, 15, 21});
    tbl.push_back('{0, 29, 0, 6'b100001, 14, 20});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step_to(tbl[i].cyc);
      night = tbl[i].nt;
      chk($sformatf("vec%0d_lamps", i), 32'({X1, V1, D1, X2, V2, D2}), 32'(tbl[i].lamps));
      chk($sformatf("vec%0d_counter1", i), 32'(counter1), 32'(tbl[i].c1));
      chk($sformatf("vec%0d_counter2", i), 32'(counter2), 32'(tbl[i].c2));
    end

    // Asynchronous reset between edges in Y2.
    do_reset();
    step_to(38);
    chk("y2_before_rst_lamps", 32'({X1, V1, D1, X2, V2, D2}), 32'(6'b001010));
    #2 rs = 1'b1;
    #1;
    chk("async_rst_lamps", 32'({X1, V1, D1, X2, V2, D2}), 32'(6'b100001));
    chk("async_rst_counter1", 32'(counter1), 32'd15);
    chk("async_rst_counter2", 32'(counter2), 32'd21);
    @(negedge clk);
    rs  = 1'b0;
    cur = 0;
    chk("post_rst_c0_counter1", 32'(counter1), 32'd15);
    @(negedge clk);
    chk("post_rst_c1_counter1", 32'(counter1), 32'd14);
    chk("post_rst_c1_counter2", 32'(counter2), 32'd20);

    // Asynchronous reset while flashing.
    do_reset();
    night = 1'b1;
    step_to(23);
    chk("nf_off_before_rst", 32'({X1, V1, D1, X2, V2, D2}), 32'(6'b000000));
    #2 rs = 1'b1;
    #1;
    chk("night_rst_lamps", 32'({X1, V1, D1, X2, V2, D2}), 32'(6'b100001));
    chk("night_rst_counter1", 32'(counter1), 32'd15);
    night = 1'b0;
    @(negedge clk);
    rs  = 1'b0;
    cur = 0;
    @(negedge clk);
    cur = 1;
    chk("night_rst_c1_counter1", 32'(counter1), 32'd14);
    chk("night_rst_c1_lamps", 32'({X1, V1, D1, X2, V2, D2}), 32'(6'b100001));

    // Saturating display (T_GREEN=250) and prescaler (TICK_DIV=4).
    do_reset();
    chk("sat_c0_counter1", 32'(bc1), 32'd250);
    chk("sat_c0_counter2", 32'(bc2), 32'd255);
    chk("div_c0_counter1", 32'(cc1), 32'd15);
    step_to(1);
    chk("sat_c1_counter1", 32'(bc1), 32'd249);
    chk("sat_c1_counter2", 32'(bc2), 32'd255);
    step_to(2);
    chk("sat_c2_counter2", 32'(bc2), 32'd254);
    step_to(3);
    chk("div_c3_counter1", 32'(cc1), 32'd15);
    step_to(4);
    chk("div_c4_counter1", 32'(cc1), 32'd14);
    chk("div_c4_counter2", 32'(cc2), 32'd20);
    step_to(59);
    chk("div_c59_lamps", 32'({cX1, cV1, cD1, cX2, cV2, cD2}), 32'(6'b100001));
    chk("div_c59_counter1", 32'(cc1), 32'd1);
    step_to(60);
    chk("div_c60_lamps", 32'({cX1, cV1, cD1, cX2, cV2, cD2}), 32'(6'b010001));
    chk("div_c60_counter1", 32'(cc1), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
